// File: rtl/uart_host_pkg.sv
// Shared constants and types for the serial console host port:
// register map, ASCII control codes and the transmit sequencer states.
package uart_host_pkg;

    localparam logic [1:0] KBD   = 2'd0;
    localparam logic [1:0] KBDCR = 2'd1;
    localparam logic [1:0] DSP   = 2'd2;
    localparam logic [1:0] DSPCR = 2'd3;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        HOLD  = 2'd2,
        WAIT  = 2'd3
    } tx_state_t;

    // Lower-case ASCII letters map to upper case; everything else passes through.
    function automatic logic [7:0] to_upper(input logic [7:0] b);
        logic [7:0] r;
        if ((b >= 8'h61) && (b <= 8'h7A)) begin
            r = b - 8'h20;
        end else begin
            r = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. A push into a full FIFO is accepted only when
// a pop happens in the same cycle; a pop from an empty FIFO is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    import uart_host_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             empty_r;
    logic             full_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests and compute the next occupancy.
    always_comb begin
        do_pop_s  = pop & ~empty_r;
        do_push_s = push & (~full_r | do_pop_s);
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + (AW+1)'(1);
            2'b01:   count_nxt_s = count_r - (AW+1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == '0);
            full_r  <= (count_nxt_s == (AW+1)'(DEPTH));
        end
    end

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign empty = empty_r;
    assign full  = full_r;

endmodule

// File: rtl/uart_host_port.sv
// Host side of the serial console: PIA-style KBD/KBDCR/DSP/DSPCR registers
// over buffered RX and TX byte streams, with optional upcasing and CR->CR LF.
module uart_host_port #(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16,
    parameter bit UPCASE   = 1'b1,
    parameter bit CRLF     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       irq_rx
);
    import uart_host_pkg::*;

    logic [7:0] rx_byte_s;
    logic [7:0] rx_head_s;
    logic       rx_push_s;
    logic       rx_pop_s;
    logic       rx_empty_s;
    logic       rx_full_s;

    logic [7:0] tx_din_s;
    logic [7:0] tx_head_s;
    logic       tx_push_s;
    logic       tx_pop_s;
    logic       tx_empty_s;
    logic       tx_full_s;

    logic       rd_s;
    logic       wr_s;
    logic       ovr_set_s;
    logic       drop_set_s;
    logic       flag_clr_s;
    logic [7:0] rdata_s;

    logic [7:0] dout_r;
    logic       rx_overrun_r;
    logic       tx_drop_r;
    tx_state_t  state_r;
    logic       tx_start_r;
    logic [7:0] tx_data_r;
    logic       pend_lf_r;

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push_s),
        .pop   (rx_pop_s),
        .din   (rx_byte_s),
        .dout  (rx_head_s),
        .empty (rx_empty_s),
        .full  (rx_full_s)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push_s),
        .pop   (tx_pop_s),
        .din   (tx_din_s),
        .dout  (tx_head_s),
        .empty (tx_empty_s),
        .full  (tx_full_s)
    );

    // Bus decode and FIFO request generation; a pop frees room for a same-cycle push.
    always_comb begin
        rd_s       = cs & ~we;
        wr_s       = cs & we;
        rx_byte_s  = UPCASE ? to_upper(rx_data) : rx_data;
        rx_pop_s   = rd_s & (addr == KBD) & ~rx_empty_s;
        rx_push_s  = rx_valid & (~rx_full_s | rx_pop_s);
        ovr_set_s  = rx_valid & rx_full_s & ~rx_pop_s;
        tx_din_s   = {1'b0, din[6:0]};
        tx_pop_s   = (state_r == IDLE) & ~tx_empty_s & ~tx_busy;
        tx_push_s  = wr_s & (addr == DSP);
        drop_set_s = tx_push_s & tx_full_s & ~tx_pop_s;
        flag_clr_s = wr_s & (addr == DSPCR);
    end

    // Read data multiplexer.
    always_comb begin
        case (addr)
            KBD:     rdata_s = rx_empty_s ? 8'h00 : {1'b1, rx_head_s[6:0]};
            KBDCR:   rdata_s = {~rx_empty_s, 7'b0000000};
            DSP:     rdata_s = {tx_full_s, 7'b0000000};
            DSPCR:   rdata_s = {6'b000000, tx_drop_r, rx_overrun_r};
            default: rdata_s = 8'h00;
        endcase
    end

    // Registered read data and sticky error flags (a set beats a clear).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_r       <= 8'h00;
            rx_overrun_r <= 1'b0;
            tx_drop_r    <= 1'b0;
        end else begin
            if (rd_s) begin
                dout_r <= rdata_s;
            end
            if (ovr_set_s) begin
                rx_overrun_r <= 1'b1;
            end else if (flag_clr_s) begin
                rx_overrun_r <= 1'b0;
            end
            if (drop_set_s) begin
                tx_drop_r <= 1'b1;
            end else if (flag_clr_s) begin
                tx_drop_r <= 1'b0;
            end
        end
    end

    // Transmit sequencer; HOLD gives the transmitter a cycle to raise busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            tx_start_r <= 1'b0;
            tx_data_r  <= 8'h00;
            pend_lf_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (tx_pop_s) begin
                        tx_data_r  <= tx_head_s;
                        pend_lf_r  <= CRLF && (tx_head_s == ASCII_CR);
                        tx_start_r <= 1'b1;
                        state_r    <= START;
                    end
                end
                START: begin
                    tx_start_r <= 1'b0;
                    state_r    <= HOLD;
                end
                HOLD: begin
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (!tx_busy) begin
                        if (pend_lf_r) begin
                            tx_data_r  <= ASCII_LF;
                            pend_lf_r  <= 1'b0;
                            tx_start_r <= 1'b1;
                            state_r    <= START;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_start_r <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign dout     = dout_r;
    assign tx_start = tx_start_r;
    assign tx_data  = tx_data_r;
    assign irq_rx   = ~rx_empty_s;

endmodule

// File: tb/tb_uart_host_port.sv
// Directed self-checking bench for uart_host_port with a simple transmitter
// model that stays busy for 10 cycles after each start pulse.
module tb_uart_host_port;

    logic       clk;
    logic       rst_n;
    logic       cs;
    logic       we;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       irq_rx;

    int         errors;
    int         checks;
    logic       hold_busy;
    logic [3:0] busy_cnt;
    logic       prev_start;
    logic       wide_err;
    logic [7:0] cap[$];

    uart_host_port dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .we       (we),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .irq_rx   (irq_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tx_busy = hold_busy | (busy_cnt != 4'd0);

    // Transmitter model: busy for 10 cycles after a start pulse.
    always @(posedge clk) begin
        if (!rst_n) begin
            busy_cnt <= 4'd0;
        end else if (tx_start) begin
            busy_cnt <= 4'd10;
        end else if (busy_cnt != 4'd0) begin
            busy_cnt <= busy_cnt - 4'd1;
        end
    end

    // Capture transmitted bytes and detect start pulses longer than one cycle.
    always @(posedge clk) begin
        if (tx_start && prev_start) begin
            wide_err <= 1'b1;
        end
        prev_start <= tx_start;
        if (tx_start) begin
            cap.push_back(tx_data);
        end
    end

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0;
        d = dout;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] v);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = a; din = v;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %02h expected 00", dout); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h expected 00", tx_data); end
        checks++; if (irq_rx !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq_rx); end
        bus_read(2'd1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_kbdcr: got %02h expected 00", d); end
    endtask

    task automatic test_rx_path;
        logic [7:0] d;
        rx_send(8'h61);
        checks++; if (irq_rx !== 1'b1) begin errors++; $display("FAIL rx_irq_set: got %b expected 1", irq_rx); end
        bus_read(2'd1, d);
        checks++; if (d !== 8'h80) begin errors++; $display("FAIL rx_kbdcr_full: got %02h expected 80", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'hC1) begin errors++; $display("FAIL rx_kbd: got %02h expected c1", d); end
        bus_read(2'd1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rx_kbdcr_empty: got %02h expected 00", d); end
        checks++; if (irq_rx !== 1'b0) begin errors++; $display("FAIL rx_irq_clr: got %b expected 0", irq_rx); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rx_kbd_empty: got %02h expected 00", d); end
    endtask

    task automatic test_upcase_bounds;
        logic [7:0] d;
        rx_send(8'h60);
        rx_send(8'h7A);
        rx_send(8'h7B);
        bus_read(2'd0, d);
        checks++; if (d !== 8'hE0) begin errors++; $display("FAIL upcase_60: got %02h expected e0", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'hDA) begin errors++; $display("FAIL upcase_7a: got %02h expected da", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'hFB) begin errors++; $display("FAIL upcase_7b: got %02h expected fb", d); end
    endtask

    task automatic test_rx_overrun;
        logic [7:0] d;
        logic [7:0] e;
        for (int i = 0; i < 17; i++) rx_send(8'h30 + 8'(i));
        bus_read(2'd3, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL ovr_flag: got %02h expected 01", d); end
        for (int i = 0; i < 16; i++) begin
            bus_read(2'd0, d);
            e = 8'hB0 + 8'(i);
            checks++; if (d !== e) begin errors++; $display("FAIL ovr_read%0d: got %02h expected %02h", i, d, e); end
        end
        bus_read(2'd0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL ovr_dropped: got %02h expected 00", d); end
        bus_write(2'd3, 8'h00);
        bus_read(2'd3, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL ovr_clear: got %02h expected 00", d); end
    endtask

    task automatic test_simultaneous;
        logic [7:0] d;
        logic [7:0] e;
        for (int i = 0; i < 16; i++) rx_send(8'h10 + 8'(i));
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = 2'd0; rx_valid = 1'b1; rx_data = 8'h42;
        @(negedge clk);
        cs = 1'b0; rx_valid = 1'b0;
        d = dout;
        checks++; if (d !== 8'h90) begin errors++; $display("FAIL sim_first: got %02h expected 90", d); end
        bus_read(2'd3, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL sim_no_ovr: got %02h expected 00", d); end
        for (int i = 1; i < 17; i++) begin
            bus_read(2'd0, d);
            e = (i == 16) ? 8'hC2 : (8'h90 + 8'(i));
            checks++; if (d !== e) begin errors++; $display("FAIL sim_read%0d: got %02h expected %02h", i, d, e); end
        end
        bus_read(2'd0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL sim_count16: got %02h expected 00", d); end
    endtask

    task automatic test_tx_crlf;
        int n;
        cap.delete();
        wide_err = 1'b0;
        bus_write(2'd2, 8'h8D);
        @(negedge clk);
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL crlf_latency: got %b expected 1", tx_start); end
        checks++; if (tx_data !== 8'h0D) begin errors++; $display("FAIL crlf_data_cr: got %02h expected 0d", tx_data); end
        n = 0;
        while (cap.size() < 2 && n < 200) begin @(negedge clk); n++; end
        repeat (30) @(negedge clk);
        checks++; if (cap.size() !== 2) begin errors++; $display("FAIL crlf_count: got %0d expected 2", cap.size()); end
        if (cap.size() >= 2) begin
            checks++; if (cap[0] !== 8'h0D) begin errors++; $display("FAIL crlf_first: got %02h expected 0d", cap[0]); end
            checks++; if (cap[1] !== 8'h0A) begin errors++; $display("FAIL crlf_second: got %02h expected 0a", cap[1]); end
        end
        bus_write(2'd2, 8'h41);
        repeat (40) @(negedge clk);
        checks++; if (cap.size() !== 3) begin errors++; $display("FAIL plain_count: got %0d expected 3", cap.size()); end
        if (cap.size() >= 3) begin
            checks++; if (cap[2] !== 8'h41) begin errors++; $display("FAIL plain_data: got %02h expected 41", cap[2]); end
        end
        checks++; if (wide_err !== 1'b0) begin errors++; $display("FAIL start_width: got %b expected 0", wide_err); end
    endtask

    task automatic test_tx_full;
        logic [7:0] d;
        int n;
        hold_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            cs = 1'b1; we = 1'b1; addr = 2'd2; din = 8'h50 + 8'(i);
        end
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
        bus_read(2'd2, d);
        checks++; if (d !== 8'h80) begin errors++; $display("FAIL txfull_dsp: got %02h expected 80", d); end
        bus_read(2'd3, d);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL txfull_drop: got %02h expected 02", d); end
        cap.delete();
        hold_busy = 1'b0;
        n = 0;
        while (cap.size() < 16 && n < 2000) begin @(negedge clk); n++; end
        repeat (50) @(negedge clk);
        checks++; if (cap.size() !== 16) begin errors++; $display("FAIL txfull_count: got %0d expected 16", cap.size()); end
        for (int i = 0; i < 16; i++) begin
            if (i < cap.size()) begin
                checks++;
                if (cap[i] !== 8'h50 + 8'(i)) begin
                    errors++; $display("FAIL txfull_byte%0d: got %02h expected %02h", i, cap[i], 8'h50 + 8'(i));
                end
            end
        end
        bus_write(2'd3, 8'hFF);
        bus_read(2'd3, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL txfull_clear: got %02h expected 00", d); end
    endtask

    task automatic test_reset_mid_transfer;
        logic [7:0] d;
        int n;
        rx_send(8'h55);
        bus_read(2'd1, d);
        checks++; if (d !== 8'h80) begin errors++; $display("FAIL mid_pre_kbdcr: got %02h expected 80", d); end
        cap.delete();
        bus_write(2'd2, 8'h0D);
        n = 0;
        while (cap.size() < 1 && n < 50) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        checks++; if (cap.size() !== 1) begin errors++; $display("FAIL mid_pre_start: got %0d expected 1", cap.size()); end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL mid_dout: got %02h expected 00", dout); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL mid_tx_start: got %b expected 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx_data: got %02h expected 00", tx_data); end
        checks++; if (irq_rx !== 1'b0) begin errors++; $display("FAIL mid_irq: got %b expected 0", irq_rx); end
        repeat (40) @(negedge clk);
        checks++; if (cap.size() !== 1) begin errors++; $display("FAIL mid_no_lf: got %0d expected 1", cap.size()); end
        bus_read(2'd1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL mid_kbdcr: got %02h expected 00", d); end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0; cs = 1'b0; we = 1'b0; addr = 2'd0; din = 8'h00;
        rx_valid = 1'b0; rx_data = 8'h00; hold_busy = 1'b0; wide_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_rx_path();
        test_upcase_bounds();
        test_rx_overrun();
        test_simultaneous();
        test_tx_crlf();
        test_tx_full();
        test_reset_mid_transfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_host_port.md
# uart_host_port

Byte-level host side of the serial console link: consumes received bytes from the async receiver and feeds bytes to the async transmitter. Presents an Apple-1 PIA-style four-register interface (KBD, KBDCR, DSP, DSPCR) to the CPU bus. Buffers both directions in FIFOs. Optionally upper-cases received letters and expands outgoing CR to CR LF. Sits between the CPU address decoder and the serial transmitter/receiver pair.

## Interface
Parameters:
- RX_DEPTH, 16, RX FIFO entries (power of 2, ≥2)
- TX_DEPTH, 16, TX FIFO entries (power of 2, ≥2)
- UPCASE, 1, map 0x61–0x7A to 0x41–0x5A on RX push
- CRLF, 1, follow every transmitted 0x0D with 0x0A

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, synchronous, active-low
- cs  in  1  register select strobe, one cycle per access
- we  in  1  1 = write, 0 = read (qualified by cs)
- addr  in  2  0 KBD, 1 KBDCR, 2 DSP, 3 DSPCR
- din  in  8  write data
- dout  out  8  read data, registered
- rx_valid  in  1  one-cycle pulse from the receiver, byte present
- rx_data  in  8  received byte, valid with rx_valid
- tx_start  out  1  one-cycle start pulse to the transmitter
- tx_data  out  8  byte to transmit, held stable from START until return to IDLE
- tx_busy  in  1  transmitter busy
- irq_rx  out  1  RX FIFO non-empty (level)

## Operation
- RX push: on rx_valid, the byte (case-mapped if UPCASE) is written to the RX FIFO. If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and sticky rx_overrun is set.
- KBD read: when the FIFO is non-empty, returns {1, head[6:0]} and pops. When empty, returns 0x00 with no pop.
- KBDCR read: returns {~rx_empty, 7'b0}. Writes are ignored.
- DSP write: pushes {0, din[6:0]} into the TX FIFO. If full, the byte is dropped and sticky tx_drop is set.
- DSP read: returns {tx_full, 7'b0}. Bit 7 = busy; the monitor polls this bit.
- DSPCR read: returns {6'b0, tx_drop, rx_overrun}. Any DSPCR write clears both flags. A set event in the same cycle as the clear wins.
- TX FSM states and transitions:
  - IDLE: if TX FIFO non-empty and !tx_busy, pop into tx_data, latch pend_lf = CRLF && byte==0x0D, go to START.
  - START: tx_start=1 for exactly one cycle, then go to HOLD.
  - HOLD: one cycle, lets tx_busy rise, then go to WAIT.
  - WAIT: when !tx_busy, if pend_lf then load tx_data=0x0A, clear pend_lf, go to START; otherwise go to IDLE.
- Simultaneous push and pop on either FIFO: both take effect; the count is unchanged.
- Count arithmetic: counts are log2(DEPTH)+1 bits wide. Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.

## Timing
- Reset values (rst_n low at a clk edge):
  - dout=0x00, tx_start=0, tx_data=0x00, irq_rx=0
  - FIFOs empty, flags clear, FSM in IDLE, pend_lf=0
- Reset mid-transfer: tx_start is forced low on the next edge. A partially sent CR LF pair is abandoned; the LF is not sent after reset.
- Read latency: dout is updated on the edge that samples cs & ~we and is valid the following cycle. The pop happens on the same edge. Data is held until the next read.
- rx_valid to KBDCR bit 7 visible: 1 cycle. irq_rx rises in the same cycle.
- DSP write to tx_start: 2 cycles minimum (write edge, then IDLE pop edge, then START).
- Full RX FIFO with a KBD read and rx_valid in the same cycle: the pop and push both occur and no overrun is flagged.
- Empty RX FIFO with a KBD read and rx_valid in the same cycle: the read returns 0x00 and the byte is stored.

## Structure
- Package uart_host_pkg holds:
  - register address constants KBD/KBDCR/DSP/DSPCR
  - ASCII_CR=0x0D, ASCII_LF=0x0A
  - TX FSM state encoding (IDLE, START, HOLD, WAIT)
- One sub-module, sync_fifo (parameters WIDTH, DEPTH), instantiated twice.
  - Ports: push, pop, din, dout (head, show-ahead), empty, full.
  - Synchronous active-low reset.

## Test plan
- Reset: hold rst_n low during WAIT with pend_lf set -> after release, all outputs are 0, no LF is emitted, and KBDCR reads 0x00.
- RX path: rx_valid with 0x61 -> KBDCR reads 0x80, KBD reads 0xC1, KBDCR then reads 0x00. A further KBD read returns 0x00.
- RX overrun: push 17 bytes into a 16-deep FIFO without reads -> DSPCR reads 0x01. Sixteen KBD reads return the first 16 bytes in order. A DSPCR write clears the flag to 0x00.
- TX CRLF: write DSP 0x8D with a transmitter model (busy for 10 cycles after each start) -> tx_start pulses twice, tx_data is 0x0D then 0x0A, and each pulse is one cycle wide.
- TX full: write 17 bytes back-to-back while tx_busy is held high -> DSP reads 0x80, DSPCR bit 1 is set, and after tx_busy falls exactly 16 bytes go out in order.
- Simultaneous events: RX FIFO full, KBD read and rx_valid 0x42 in the same cycle -> no overrun, the count stays 16, and the last entry read out is 0xC2.
